// File: rtl/risc_perf_pkg.sv
// risc_perf_pkg: shared state and trace-entry types for the performance/trace monitor
package risc_perf_pkg;
    localparam int PKG_PC_W = 16;
    localparam int PKG_IR_W = 16;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} perf_state_e;
    typedef struct packed {
        logic [PKG_PC_W-1:0] pc;
        logic [PKG_IR_W-1:0] ir;
    } trace_entry_t;
endpackage

// File: rtl/risc_trace_ram.sv
// risc_trace_ram: DEPTH x W trace store, one synchronous write port, one asynchronous read port
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr/o_rdata combinational read port.
module risc_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/risc_perf_trace.sv
// risc_perf_trace: cycle/instruction counters plus a retirement trace drained oldest-first after halt
// Ports: clk, rst_n (async active-low); holt/instr_valid/pc/ir taps from the core; clr sync clear;
//        cycle_cnt/instr_cnt/cnt_ovf counters; halted status; tr_valid/tr_ready/tr_pc/tr_ir/tr_count drain port.
module risc_perf_trace
    import risc_perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PC_W     = 16,
    parameter int IR_W     = 16,
    parameter int DEPTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     holt,
    input  logic                     instr_valid,
    input  logic [PC_W-1:0]          pc,
    input  logic [IR_W-1:0]          ir,
    input  logic                     clr,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         instr_cnt,
    output logic                     cnt_ovf,
    output logic                     halted,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [PC_W-1:0]          tr_pc,
    output logic [IR_W-1:0]          tr_ir,
    output logic [$clog2(DEPTH):0]   tr_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] ir;
    } entry_t;
    perf_state_e    r_state;
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FW-1:0]  r_fill, r_tr_count;
    logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
    logic           r_ovf, r_halted;
    logic           w_run, w_we, w_pop;
    logic [AW-1:0]  w_wr_next;
    logic [FW-1:0]  w_fill_run;
    logic [CNT_W:0] w_cyc_nx, w_ins_nx;
    entry_t         w_rd;
    // Returns {overflow, next value}: all-ones either sticks or wraps, and flags it.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
        return (&v) ? {1'b1, (SATURATE != 0) ? v : {CNT_W{1'b0}}} : {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
    endfunction
    assign w_run      = (r_state == RUN);
    assign w_we       = w_run & instr_valid;
    assign w_pop      = tr_valid & tr_ready;
    assign w_wr_next  = r_wr_ptr + AW'(w_we);
    // A full buffer keeps its fill at DEPTH; the write simply overwrites the oldest slot.
    assign w_fill_run = (instr_valid && r_fill != FW'(DEPTH)) ? r_fill + FW'(1) : r_fill;
    assign w_cyc_nx   = bump(r_cycle_cnt);
    assign w_ins_nx   = bump(r_instr_cnt);
    risc_trace_ram #(.DEPTH(DEPTH), .W(PC_W + IR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({pc, ir}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state     <= RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_tr_count  <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_ovf       <= 1'b0;
            r_halted    <= 1'b0;
        end else if (clr) begin
            r_state     <= RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_tr_count  <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_ovf       <= 1'b0;
            r_halted    <= 1'b0;
        end else if (w_run) begin
            if (!holt) r_cycle_cnt <= w_cyc_nx[CNT_W-1:0];
            if (instr_valid) r_instr_cnt <= w_ins_nx[CNT_W-1:0];
            r_ovf    <= r_ovf | (!holt & w_cyc_nx[CNT_W]) | (instr_valid & w_ins_nx[CNT_W]);
            r_wr_ptr <= w_wr_next;
            r_fill   <= w_fill_run;
            if (holt) begin
                r_state    <= (w_fill_run != '0) ? DRAIN : DONE;
                r_halted   <= 1'b1;
                // Oldest surviving entry sits fill slots behind the write pointer.
                r_rd_ptr   <= w_wr_next - w_fill_run[AW-1:0];
                r_tr_count <= w_fill_run;
            end
        end else if (r_state == DRAIN && w_pop) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_fill     <= r_fill - FW'(1);
            r_tr_count <= r_tr_count - FW'(1);
            if (r_fill == FW'(1)) r_state <= DONE;
        end
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
    assign cnt_ovf   = r_ovf;
    assign halted    = r_halted;
    assign tr_count  = r_tr_count;
    // tr_count is only non-zero while draining, so it doubles as the valid decode.
    assign tr_valid  = (r_tr_count != '0);
    assign tr_pc     = tr_valid ? w_rd.pc : '0;
    assign tr_ir     = tr_valid ? w_rd.ir : '0;
endmodule

// File: tb/tb_risc_perf_trace.sv
// tb_risc_perf_trace: table, directed and random checks of risc_perf_trace against a queue-based model
module tb_risc_perf_trace;
    import risc_perf_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, holt = 1'b0, instr_valid = 1'b0, clr = 1'b0, tr_ready = 1'b0;
    logic [15:0] pc = '0, ir = '0;
    logic [31:0] cycle_cnt, instr_cnt;
    logic        cnt_ovf, halted, tr_valid;
    logic [15:0] tr_pc, tr_ir;
    logic [4:0]  tr_count;
    logic [3:0]  s_cyc, s_ins, w_cyc, w_ins;
    logic        s_ovf, s_halt, s_tv, w_ovf, w_halt, w_tv;
    logic [15:0] s_pc, s_ir, w_pc, w_ir;
    logic [4:0]  s_cnt, w_cnt;
    int checks = 0, failures = 0;
    longint m_cyc, m_ins;
    int m_state;
    trace_entry_t m_q[$];
    logic [15:0] got[$];
    typedef struct {
        logic holt, iv, rdy;
        logic [15:0] pc;
        logic [31:0] e_cyc, e_ins;
        logic e_halt, e_tv;
        logic [4:0] e_cnt;
        logic [15:0] e_pc;
    } vec_t;
    vec_t tab[14];

    always #5 clk = ~clk;

    risc_perf_trace u_dut (
        .clk(clk), .rst_n(rst_n), .holt(holt), .instr_valid(instr_valid), .pc(pc), .ir(ir), .clr(clr),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .cnt_ovf(cnt_ovf), .halted(halted),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_ir(tr_ir), .tr_count(tr_count)
    );
    risc_perf_trace #(.CNT_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .holt(holt), .instr_valid(instr_valid), .pc(pc), .ir(ir), .clr(clr),
        .cycle_cnt(s_cyc), .instr_cnt(s_ins), .cnt_ovf(s_ovf), .halted(s_halt),
        .tr_valid(s_tv), .tr_ready(tr_ready), .tr_pc(s_pc), .tr_ir(s_ir), .tr_count(s_cnt)
    );
    risc_perf_trace #(.CNT_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .holt(holt), .instr_valid(instr_valid), .pc(pc), .ir(ir), .clr(clr),
        .cycle_cnt(w_cyc), .instr_cnt(w_ins), .cnt_ovf(w_ovf), .halted(w_halt),
        .tr_valid(w_tv), .tr_ready(tr_ready), .tr_pc(w_pc), .tr_ir(w_ir), .tr_count(w_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cyc = 0;
        m_ins = 0;
        m_state = 0;
        m_q.delete();
    endtask

    // Spec-level behaviour: a bounded history of retirements, drained front-first after halt.
    task automatic model_step();
        if (clr) model_clear();
        else if (m_state == 0) begin
            if (!holt) m_cyc++;
            if (instr_valid) begin
                m_ins++;
                m_q.push_back('{pc: pc, ir: ir});
                if (m_q.size() > 16) void'(m_q.pop_front());
            end
            if (holt) m_state = (m_q.size() > 0) ? 1 : 2;
        end else if (m_state == 1 && tr_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_state = 2;
        end
    endtask

    task automatic chk_trace(input string p, input logic h, input logic v, input logic [4:0] c,
                             input logic [15:0] tp, input logic [15:0] ti);
        logic ev;
        ev = (m_state == 1);
        chk({p, "_halted"}, h, m_state != 0);
        chk({p, "_tr_valid"}, v, ev);
        chk({p, "_tr_count"}, c, ev ? m_q.size() : 0);
        chk({p, "_tr_pc"}, tp, ev ? m_q[0].pc : 16'h0);
        chk({p, "_tr_ir"}, ti, ev ? m_q[0].ir : 16'h0);
    endtask

    task automatic compare_all();
        chk("cycle_cnt", cycle_cnt, m_cyc[31:0]);
        chk("instr_cnt", instr_cnt, m_ins[31:0]);
        chk("cnt_ovf", cnt_ovf, (m_cyc >= 64'h1_0000_0000) || (m_ins >= 64'h1_0000_0000));
        chk_trace("main", halted, tr_valid, tr_count, tr_pc, tr_ir);
        chk("sat_cyc", s_cyc, (m_cyc > 15) ? 15 : m_cyc);
        chk("sat_ins", s_ins, (m_ins > 15) ? 15 : m_ins);
        chk("sat_ovf", s_ovf, (m_cyc > 15) || (m_ins > 15));
        chk("wrap_cyc", w_cyc, m_cyc % 16);
        chk("wrap_ins", w_ins, m_ins % 16);
        chk("wrap_ovf", w_ovf, (m_cyc > 15) || (m_ins > 15));
        chk_trace("sat", s_halt, s_tv, s_cnt, s_pc, s_ir);
        chk_trace("wrap", w_halt, w_tv, w_cnt, w_pc, w_ir);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
        chk("rst_cnt_ovf", cnt_ovf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_tr_valid", tr_valid, 0);
        chk("rst_tr_count", tr_count, 0);
        chk("rst_tr_pc", tr_pc, 0);
        chk("rst_tr_ir", tr_ir, 0);
        chk("rst_sat_cyc", s_cyc, 0);
        chk("rst_wrap_cyc", w_cyc, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        holt = 1'b0;
        instr_valid = 1'b0;
        tr_ready = 1'b0;
        cyc();
        clr = 1'b0;
    endtask

    task automatic retire(input logic [15:0] p);
        instr_valid = 1'b1;
        pc = p;
        ir = p + 16'h0100;
        cyc();
        instr_valid = 1'b0;
    endtask

    task automatic drain_collect(input int stall_at);
        logic [15:0] hp, hi;
        logic [4:0] hc;
        got.delete();
        tr_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (!tr_valid) break;
            if (k == stall_at) begin
                hp = tr_pc;
                hi = tr_ir;
                hc = tr_count;
                tr_ready = 1'b0;
                repeat (3) begin
                    cyc();
                    chk("stall_pc", tr_pc, hp);
                    chk("stall_ir", tr_ir, hi);
                    chk("stall_cnt", tr_count, hc);
                    chk("stall_valid", tr_valid, 1);
                end
                tr_ready = 1'b1;
            end
            got.push_back(tr_pc);
            cyc();
        end
        tr_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;
        for (int i = 0; i < 10; i++)
            tab[i] = '{holt: 0, iv: (i % 2 == 0), rdy: 0, pc: 16'(i), e_cyc: i + 1, e_ins: i / 2 + 1,
                       e_halt: 0, e_tv: 0, e_cnt: 0, e_pc: 0};
        tab[10] = '{holt: 1, iv: 0, rdy: 0, pc: 0, e_cyc: 10, e_ins: 5, e_halt: 1, e_tv: 1, e_cnt: 5, e_pc: 0};
        tab[11] = '{holt: 1, iv: 0, rdy: 1, pc: 0, e_cyc: 10, e_ins: 5, e_halt: 1, e_tv: 1, e_cnt: 4, e_pc: 2};
        tab[12] = '{holt: 0, iv: 0, rdy: 0, pc: 0, e_cyc: 10, e_ins: 5, e_halt: 1, e_tv: 1, e_cnt: 4, e_pc: 2};
        tab[13] = '{holt: 0, iv: 0, rdy: 1, pc: 0, e_cyc: 10, e_ins: 5, e_halt: 1, e_tv: 1, e_cnt: 3, e_pc: 4};
        do_reset();
        foreach (tab[i]) begin
            holt = tab[i].holt;
            instr_valid = tab[i].iv;
            tr_ready = tab[i].rdy;
            pc = tab[i].pc;
            ir = tab[i].pc + 16'h0100;
            cyc();
            chk("tab_cycle_cnt", cycle_cnt, tab[i].e_cyc);
            chk("tab_instr_cnt", instr_cnt, tab[i].e_ins);
            chk("tab_halted", halted, tab[i].e_halt);
            chk("tab_tr_valid", tr_valid, tab[i].e_tv);
            chk("tab_tr_count", tr_count, tab[i].e_cnt);
            chk("tab_tr_pc", tr_pc, tab[i].e_pc);
        end
        // 20 retirements into 16 slots: PC 4..19 survive, in order.
        do_clr();
        for (int i = 0; i < 20; i++) retire(16'(i));
        holt = 1'b1;
        cyc();
        chk("wrap_fill_count", tr_count, 16);
        drain_collect(-1);
        chk("wrap_drained_n", got.size(), 16);
        foreach (got[i]) chk("wrap_drained_pc", got[i], i + 4);
        chk("wrap_done_halted", halted, 1);
        chk("wrap_done_valid", tr_valid, 0);
        // Back-pressure mid-drain must neither lose nor duplicate entries.
        do_clr();
        for (int i = 0; i < 6; i++) retire(16'(i + 16'h0200));
        holt = 1'b1;
        cyc();
        drain_collect(2);
        chk("stall_drained_n", got.size(), 6);
        foreach (got[i]) chk("stall_drained_pc", got[i], i + 16'h0200);
        // Free-running cycles exercise saturate versus wrap on the 4-bit instances.
        do_clr();
        holt = 1'b0;
        repeat (20) cyc();
        chk("sat20_cyc", s_cyc, 15);
        chk("sat20_ovf", s_ovf, 1);
        chk("wrap20_cyc", w_cyc, 4);
        chk("wrap20_ovf", w_ovf, 1);
        // holt together with a retirement: recorded last, no cycle counted.
        do_clr();
        retire(16'h0010);
        retire(16'h0011);
        snap = cycle_cnt;
        holt = 1'b1;
        instr_valid = 1'b1;
        pc = 16'h0042;
        ir = 16'h1042;
        cyc();
        instr_valid = 1'b0;
        chk("holt_iv_cyc_frozen", cycle_cnt, snap);
        chk("holt_iv_instr", instr_cnt, 3);
        drain_collect(-1);
        chk("holt_iv_n", got.size(), 3);
        if (got.size() == 3) chk("holt_iv_last_pc", got[2], 16'h0042);
        // holt with empty trace goes straight to DONE and stays there.
        do_clr();
        holt = 1'b1;
        cyc();
        chk("empty_halted", halted, 1);
        holt = 1'b0;
        tr_ready = 1'b1;
        repeat (4) begin
            cyc();
            chk("empty_no_valid", tr_valid, 0);
            chk("empty_still_halted", halted, 1);
        end
        // clr from DONE returns to RUN with zeroed counters.
        do_clr();
        chk("clr_done_halted", halted, 0);
        chk("clr_done_cyc", cycle_cnt, 0);
        chk("clr_done_ins", instr_cnt, 0);
        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 5; i++) retire(16'(i + 16'h0300));
        holt = 1'b1;
        tr_ready = 1'b1;
        cyc();
        cyc();
        holt = 1'b0;
        tr_ready = 1'b0;
        do_reset();
        cyc();
        // Randomised runs against the model.
        for (int r = 0; r < 8; r++) begin
            int run_len;
            do_clr();
            run_len = $urandom_range(5, 60);
            for (int k = 0; k < 300; k++) begin
                instr_valid = $urandom_range(0, 1);
                pc = 16'($urandom);
                ir = 16'($urandom);
                tr_ready = ($urandom_range(0, 3) != 0);
                holt = (k >= run_len) ? ($urandom_range(0, 4) != 0 || m_state == 0) : 1'b0;
                cyc();
                if (m_state == 2 && k > run_len + 2) break;
            end
            chk("rand_reached_done", m_state, 2);
        end
        holt = 1'b0;
        instr_valid = 1'b0;
        tr_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
